// File: rtl/memory_read_arbiter_pkg.sv
// Shared definitions for the multi-channel memory read arbiter.
//   DEFAULT_MEMORY_LATENCY : read latency of the shared memory in the default build
//   ptr_width()            : width of a round-robin pointer over n channels (min 1 bit)
package memory_read_arbiter_pkg;

    localparam int DEFAULT_N_CHANNELS     = 4;
    localparam int DEFAULT_ADDR_WIDTH     = 10;
    localparam int DEFAULT_MEMORY_WIDTH   = 32;
    localparam int DEFAULT_MEMORY_LATENCY = 1;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/memory_read_arbiter_if.sv
// Bus bundle between the fetch-stage requesters, the arbiter and the shared memory.
//   ch_valid/ch_addr          : per-channel read requests (channel i at [i*AW +: AW])
//   ch_ready/ch_data          : per-channel completion pulse and shared return data
//   broadcast_addr/_valid     : address tag of ch_data
//   mem_valid/mem_addr        : read command to the memory
//   mem_data                  : memory read data, fixed latency after mem_valid
// Modports: slave = arbiter view, master = requester/memory environment view.
interface memory_read_arbiter_if #(
    parameter int N_CHANNELS        = 4,
    parameter int MEMORY_ADDR_WIDTH = 10,
    parameter int MEMORY_WIDTH      = 32
);
    logic [N_CHANNELS-1:0]                   ch_valid;
    logic [N_CHANNELS*MEMORY_ADDR_WIDTH-1:0] ch_addr;
    logic [N_CHANNELS-1:0]                   ch_ready;
    logic [MEMORY_WIDTH-1:0]                 ch_data;
    logic [MEMORY_ADDR_WIDTH-1:0]            broadcast_addr;
    logic                                    broadcast_valid;
    logic                                    mem_valid;
    logic [MEMORY_ADDR_WIDTH-1:0]            mem_addr;
    logic [MEMORY_WIDTH-1:0]                 mem_data;

    modport slave (
        input  ch_valid, ch_addr, mem_data,
        output ch_ready, ch_data, broadcast_addr, broadcast_valid, mem_valid, mem_addr
    );

    modport master (
        output ch_valid, ch_addr, mem_data,
        input  ch_ready, ch_data, broadcast_addr, broadcast_valid, mem_valid, mem_addr
    );
endinterface

// File: rtl/memory_read_arbiter_rr_arbiter.sv
// Round-robin picker: grants the first requester at or after ptr (wrapping)
// and returns the pointer to use next cycle (winner+1, or ptr when idle).
//   req      : request vector
//   ptr      : current round-robin pointer
//   grant    : one-hot grant (all zero when req is empty)
//   ptr_next : updated pointer
module rr_arbiter
    import memory_read_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] ptr_next
);
    logic found;
    int   idx;

    always_comb begin
        grant    = '0;
        ptr_next = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_next   = PW'((idx + 1) % N);
            end
        end
    end
endmodule

// File: rtl/memory_read_arbiter.sv
// N-channel read arbiter in front of one fixed-latency memory port.
// Round-robin issue with address coalescing; returned data is broadcast so any
// idle requester waiting on the same address completes without a new access.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : memory_read_arbiter_if.slave (requests, completions, memory port)
module memory_read_arbiter
    import memory_read_arbiter_pkg::*;
#(
    parameter int N_CHANNELS        = DEFAULT_N_CHANNELS,
    parameter int MEMORY_ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int MEMORY_WIDTH      = DEFAULT_MEMORY_WIDTH,
    parameter int MEMORY_LATENCY    = DEFAULT_MEMORY_LATENCY
) (
    input logic                  clk,
    input logic                  rst_n,
    memory_read_arbiter_if.slave bus
);
    localparam int PW = ptr_width(N_CHANNELS);

    typedef struct packed {
        logic                         valid;
        logic [MEMORY_ADDR_WIDTH-1:0] addr;
        logic [N_CHANNELS-1:0]        mask;
    } pipe_entry_t;

    logic [MEMORY_ADDR_WIDTH-1:0] addr_a [N_CHANNELS];
    pipe_entry_t                  pipe   [MEMORY_LATENCY];
    pipe_entry_t                  head;

    logic [PW-1:0]                rr_ptr;
    logic [PW-1:0]                rr_ptr_next;
    logic [N_CHANNELS-1:0]        pending;
    logic [N_CHANNELS-1:0]        ready_q;
    logic [N_CHANNELS-1:0]        hit;
    logic [N_CHANNELS-1:0]        cand;
    logic [N_CHANNELS-1:0]        grant;
    logic [N_CHANNELS-1:0]        grant_mask;
    logic [N_CHANNELS-1:0]        ready_next;
    logic                         issue;
    logic [MEMORY_ADDR_WIDTH-1:0] win_addr;
    logic                         bvalid_q;
    logic [MEMORY_ADDR_WIDTH-1:0] baddr_q;
    logic [MEMORY_WIDTH-1:0]      data_q;

    for (genvar g = 0; g < N_CHANNELS; g++) begin : g_addr
        assign addr_a[g] = bus.ch_addr[g*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
    end

    assign head = pipe[MEMORY_LATENCY-1];

    // A channel whose ready pulse is showing this cycle still presents its old
    // request, so it is neither a hit nor a candidate until the next cycle.
    // Broadcast hits are removed before arbitration so they never cost an access.
    always_comb begin
        hit  = '0;
        cand = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            hit[i]  = head.valid & bus.ch_valid[i] & ~pending[i] & ~ready_q[i]
                    & (addr_a[i] == head.addr);
            cand[i] = rst_n & bus.ch_valid[i] & ~pending[i] & ~ready_q[i] & ~hit[i];
        end
    end

    rr_arbiter #(
        .N  (N_CHANNELS),
        .PW (PW)
    ) u_rr (
        .req      (cand),
        .ptr      (rr_ptr),
        .grant    (grant),
        .ptr_next (rr_ptr_next)
    );

    assign issue = |grant;

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (grant[i]) win_addr = addr_a[i];
        end
        grant_mask = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            grant_mask[i] = issue & cand[i] & (addr_a[i] == win_addr);
        end
    end

    always_comb begin
        ready_next = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            ready_next[i] = head.valid
                          & ((head.mask[i] & bus.ch_valid[i] & (addr_a[i] == head.addr)) | hit[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            pending  <= '0;
            ready_q  <= '0;
            bvalid_q <= 1'b0;
            baddr_q  <= '0;
            data_q   <= '0;
            for (int s = 0; s < MEMORY_LATENCY; s++) pipe[s] <= '0;
        end else begin
            rr_ptr <= rr_ptr_next;
            // Head mask bits are always pending, grant bits never are: no overlap.
            pending <= (pending & ~(head.valid ? head.mask : '0)) | grant_mask;
            pipe[0] <= '{valid: issue, addr: win_addr, mask: grant_mask};
            for (int s = 1; s < MEMORY_LATENCY; s++) pipe[s] <= pipe[s-1];
            ready_q  <= ready_next;
            bvalid_q <= head.valid;
            if (head.valid) begin
                baddr_q <= head.addr;
                data_q  <= bus.mem_data;
            end
        end
    end

    assign bus.mem_valid       = issue;
    assign bus.mem_addr        = win_addr;
    assign bus.ch_ready        = ready_q;
    assign bus.broadcast_valid = bvalid_q;
    assign bus.broadcast_addr  = baddr_q;
    assign bus.ch_data         = data_q;
endmodule

// File: tb/tb_memory_read_arbiter.sv
// Self-checking bench for memory_read_arbiter: directed scenarios plus random
// traffic on a latency-1 instance against a transaction-level model, and a
// latency-3 instance exercising latency and mid-flight reset.
module tb_memory_read_arbiter;
    localparam int N    = 4;
    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic rst3_n;
    always #5 clk = ~clk;

    memory_read_arbiter_if #(.N_CHANNELS(N), .MEMORY_ADDR_WIDTH(AW), .MEMORY_WIDTH(DW)) bus ();
    memory_read_arbiter_if #(.N_CHANNELS(N), .MEMORY_ADDR_WIDTH(AW), .MEMORY_WIDTH(DW)) bus3 ();

    memory_read_arbiter #(.N_CHANNELS(N), .MEMORY_ADDR_WIDTH(AW), .MEMORY_WIDTH(DW),
                          .MEMORY_LATENCY(LAT)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    memory_read_arbiter #(.N_CHANNELS(N), .MEMORY_ADDR_WIDTH(AW), .MEMORY_WIDTH(DW),
                          .MEMORY_LATENCY(LAT3)) u_dut3 (.clk(clk), .rst_n(rst3_n), .bus(bus3));

    // memory: contents array plus fixed-latency read pipelines
    logic [DW-1:0] mem [1024];
    logic [DW-1:0] md1;
    logic [DW-1:0] md3 [LAT3];
    always @(posedge clk) begin
        md1    <= mem[bus.mem_addr];
        md3[0] <= mem[bus3.mem_addr];
        md3[1] <= md3[0];
        md3[2] <= md3[1];
    end
    assign bus.mem_data  = md1;
    assign bus3.mem_data = md3[LAT3-1];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // transaction-level reference model
    typedef struct {
        int            due;
        logic [AW-1:0] addr;
        logic [N-1:0]  mask;
        logic [DW-1:0] data;
    } fl_t;

    fl_t           inflight[$];
    int            cyc_n = 0;
    int            rr = 0;
    logic [N-1:0]  m_pend = '0;
    logic [N-1:0]  e_ready = '0;
    logic          e_bvalid = 1'b0;
    logic [AW-1:0] e_baddr = '0;
    logic [DW-1:0] e_data = '0;

    logic [N-1:0]  v = '0;
    logic [AW-1:0] a [N];

    task automatic cycle();
        fl_t          head;
        bit           have_head;
        logic [N-1:0] hit, cand, gmask, nready;
        int           w;
        bus.ch_valid = v;
        for (int i = 0; i < N; i++) bus.ch_addr[i*AW +: AW] = a[i];
        #2;
        check("ch_ready", 64'(bus.ch_ready), 64'(e_ready));
        check("broadcast_valid", 64'(bus.broadcast_valid), 64'(e_bvalid));
        if (e_bvalid) begin
            check("broadcast_addr", 64'(bus.broadcast_addr), 64'(e_baddr));
            check("ch_data", 64'(bus.ch_data), 64'(e_data));
        end
        have_head = (inflight.size() > 0) && (inflight[0].due == cyc_n + 1);
        if (have_head) head = inflight[0];
        hit  = '0;
        cand = '0;
        for (int i = 0; i < N; i++) begin
            hit[i]  = have_head && v[i] && !m_pend[i] && !e_ready[i] && (a[i] == head.addr);
            cand[i] = v[i] && !m_pend[i] && !e_ready[i] && !hit[i];
        end
        w = -1;
        for (int j = 0; j < N; j++) begin
            int idx;
            idx = (rr + j) % N;
            if (w < 0 && cand[idx]) w = idx;
        end
        check("mem_valid", 64'(bus.mem_valid), 64'(w >= 0));
        gmask = '0;
        if (w >= 0) begin
            check("mem_addr", 64'(bus.mem_addr), 64'(a[w]));
            for (int i = 0; i < N; i++) gmask[i] = cand[i] && (a[i] == a[w]);
        end
        nready = '0;
        if (have_head) begin
            for (int i = 0; i < N; i++)
                nready[i] = (head.mask[i] && v[i] && (a[i] == head.addr)) || hit[i];
            e_bvalid = 1'b1;
            e_baddr  = head.addr;
            e_data   = head.data;
            m_pend   = m_pend & ~head.mask;
            void'(inflight.pop_front());
        end else begin
            e_bvalid = 1'b0;
        end
        if (w >= 0) begin
            m_pend = m_pend | gmask;
            rr = (w + 1) % N;
            inflight.push_back('{cyc_n + LAT + 1, a[w], gmask, mem[a[w]]});
        end
        e_ready = nready;
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic idle(input int n);
        v = '0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive3(input logic [N-1:0] vv, input logic [AW-1:0] x0, input logic [AW-1:0] x1,
                          input logic [AW-1:0] x2, input logic [AW-1:0] x3);
        bus3.ch_valid = vv;
        bus3.ch_addr  = {x3, x2, x1, x0};
        #2;
    endtask

    logic [N-1:0] pr;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        for (int i = 0; i < N; i++) a[i] = '0;
        rst_n  = 1'b0;
        rst3_n = 1'b0;
        bus.ch_valid  = '0;
        bus.ch_addr   = '0;
        bus3.ch_valid = '0;
        bus3.ch_addr  = '0;
        tick();
        tick();
        #2;
        check("reset ch_ready", 64'(bus.ch_ready), 64'h0);
        check("reset broadcast_valid", 64'(bus.broadcast_valid), 64'h0);
        check("reset ch_data", 64'(bus.ch_data), 64'h0);
        check("reset broadcast_addr", 64'(bus.broadcast_addr), 64'h0);
        check("reset mem_valid", 64'(bus.mem_valid), 64'h0);
        rst_n = 1'b1;
        tick();

        // single request: issue at cycle 0, ready at cycle 2
        mem[10'h010] = 32'hDEADBEEF;
        v = 4'b0001;
        a[0] = 10'h010;
        cycle();
        cycle();
        check("single ch_ready", 64'(bus.ch_ready), 64'h1);
        check("single ch_data", 64'(bus.ch_data), 64'hDEADBEEF);
        check("single broadcast_addr", 64'(bus.broadcast_addr), 64'h010);
        cycle();
        idle(3);

        // round robin over four distinct addresses
        v = 4'b1111;
        for (int i = 0; i < N; i++) a[i] = AW'(i + 1);
        for (int k = 0; k < 14; k++) cycle();
        idle(4);

        // coalescing: ch1 and ch3 share an address
        v = 4'b1010;
        a[1] = 10'h055;
        a[3] = 10'h055;
        cycle();
        check("coalesce no 2nd access", 64'(bus.mem_valid), 64'h0);
        cycle();
        check("coalesce ch_ready", 64'(bus.ch_ready), 64'hA);
        cycle();
        idle(3);

        // broadcast hit: ch0 joins ch2's in-flight address one cycle later
        v = 4'b0100;
        a[2] = 10'h020;
        cycle();
        v = 4'b0101;
        a[0] = 10'h020;
        cycle();
        check("hit ch_ready", 64'(bus.ch_ready), 64'h5);
        cycle();
        idle(3);

        // abandon: ch1 drops while pending, then issues a new address
        v = 4'b0010;
        a[1] = 10'h0A0;
        cycle();
        v = 4'b0000;
        cycle();
        check("abandon ch_ready", 64'(bus.ch_ready), 64'h0);
        check("abandon broadcast_valid", 64'(bus.broadcast_valid), 64'h1);
        check("abandon broadcast_addr", 64'(bus.broadcast_addr), 64'h0A0);
        v = 4'b0010;
        a[1] = 10'h0B0;
        cycle();
        cycle();
        cycle();
        idle(3);

        // random traffic with a small address pool to force coalescing and hits
        pr = '0;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] || pr[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        v[i] = 1'b1;
                        a[i] = AW'(10'h100 + $urandom_range(0, 5));
                    end else begin
                        v[i] = 1'b0;
                    end
                end else if (!e_ready[i] && $urandom_range(0, 15) == 0) begin
                    v[i] = 1'b0;
                end
            end
            pr = e_ready;
            cycle();
        end
        idle(4);

        // latency-3 instance: requests ignored under reset, then full latency
        drive3(4'b1111, 10'h001, 10'h002, 10'h003, 10'h004);
        check("L3 mem_valid in reset", 64'(bus3.mem_valid), 64'h0);
        drive3(4'b0000, 10'h000, 10'h000, 10'h000, 10'h000);
        rst3_n = 1'b1;
        tick();
        mem[10'h040] = 32'hCAFEF00D;
        drive3(4'b0010, 10'h000, 10'h040, 10'h000, 10'h000);
        check("L3 issue mem_valid", 64'(bus3.mem_valid), 64'h1);
        check("L3 issue mem_addr", 64'(bus3.mem_addr), 64'h040);
        for (int k = 1; k <= 3; k++) begin
            tick();
            #2;
            check("L3 early ch_ready", 64'(bus3.ch_ready), 64'h0);
        end
        tick();
        #2;
        check("L3 ch_ready", 64'(bus3.ch_ready), 64'h2);
        check("L3 ch_data", 64'(bus3.ch_data), 64'hCAFEF00D);
        tick();
        drive3(4'b0000, 10'h000, 10'h000, 10'h000, 10'h000);
        tick();

        // mid-flight reset one cycle after ch2 issues (pointer would be 3)
        drive3(4'b0100, 10'h000, 10'h000, 10'h041, 10'h000);
        check("L3 pre-reset mem_valid", 64'(bus3.mem_valid), 64'h1);
        tick();
        rst3_n = 1'b0;
        drive3(4'b0000, 10'h000, 10'h000, 10'h000, 10'h000);
        check("L3 reset ch_ready", 64'(bus3.ch_ready), 64'h0);
        check("L3 reset broadcast_valid", 64'(bus3.broadcast_valid), 64'h0);
        check("L3 reset ch_data", 64'(bus3.ch_data), 64'h0);
        check("L3 reset broadcast_addr", 64'(bus3.broadcast_addr), 64'h0);
        check("L3 reset mem_valid", 64'(bus3.mem_valid), 64'h0);
        tick();
        tick();
        rst3_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            #2;
            check("L3 post-reset ch_ready", 64'(bus3.ch_ready), 64'h0);
            check("L3 post-reset broadcast_valid", 64'(bus3.broadcast_valid), 64'h0);
        end
        drive3(4'b1111, 10'h061, 10'h062, 10'h063, 10'h064);
        check("L3 pointer restart mem_addr", 64'(bus3.mem_addr), 64'h061);
        tick();
        drive3(4'b0000, 10'h000, 10'h000, 10'h000, 10'h000);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/memory_read_arbiter.md
Name: memory_read_arbiter

Overview:
- Multi-channel successor to the single-requester memory read port: N_CHANNELS requesters share one fixed-latency read port.
- Round-robin arbitration with address coalescing.
- Returned data broadcast to all channels; any channel waiting on the same address completes without a second memory access.
- Sits between the per-engine fetch stages and the shared instruction/data memory.

Parameters:
N_CHANNELS, 4, number of requesting channels (>=1)
MEMORY_ADDR_WIDTH, 10, address width
MEMORY_WIDTH, 32, data width
MEMORY_LATENCY, 1, fixed memory read latency in cycles (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ch_valid  in  N_CHANNELS  per-channel read request
ch_addr  in  N_CHANNELS*MEMORY_ADDR_WIDTH  per-channel address, channel i at [i*AW +: AW]
ch_ready  out  N_CHANNELS  per-channel completion; ch_data valid for that channel this cycle
ch_data  out  MEMORY_WIDTH  shared returned data
broadcast_addr  out  MEMORY_ADDR_WIDTH  address of ch_data
broadcast_valid  out  1  ch_data/broadcast_addr valid this cycle
mem_valid  out  1  read enable to memory
mem_addr  out  MEMORY_ADDR_WIDTH  read address to memory
mem_data  in  MEMORY_WIDTH  memory read data, MEMORY_LATENCY cycles after mem_valid

Behaviour:
- One clock. rst_n is asynchronous and active-low; all state is cleared on assertion.
- Reset values: ch_ready=0, broadcast_valid=0, ch_data=0, broadcast_addr=0, mem_valid=0, pending=0, RR pointer=0.
- Requester rule: hold ch_valid=1 with ch_addr stable until ch_ready=1. ch_ready is a one-cycle pulse. A requester may issue a new request in the cycle after ch_ready.
- Candidates: channels with ch_valid=1 and pending[i]=0.
- Issue, combinational, at most one per cycle:
  - Winner is the first candidate at or after the RR pointer, wrapping modulo N_CHANNELS.
  - mem_valid=1 and mem_addr=ch_addr[winner].
  - Grant mask = all candidates whose ch_addr equals ch_addr[winner] (coalescing).
  - Masked channels set pending. The RR pointer moves to winner+1 mod N_CHANNELS.
  - No candidates: mem_valid=0 and the pointer holds.
- In-flight tracking:
  - A MEMORY_LATENCY-deep shift pipeline carries {valid, addr, mask}.
  - mem_data is sampled when the pipeline head is valid.
- Return, registered one cycle after mem_data:
  - broadcast_valid=1, broadcast_addr=head addr, ch_data=mem_data.
  - ch_ready[i]=1 when (mask[i] & ch_valid[i] & ch_addr[i]==addr) OR (broadcast hit: ch_valid[i] & !pending[i] & ch_addr[i]==addr & i not granted at issue that cycle).
  - pending is cleared for every mask bit, whether or not ready fired.
- Total latency from the issue cycle to ch_ready is MEMORY_LATENCY+1. Example: MEMORY_LATENCY=1, issue at cycle 0, ch_ready at cycle 2.
- Throughput: one new address per cycle. Memory accesses are fully pipelined.
- Boundary conditions:
  - Requester drops ch_valid while pending: the data still returns, ch_ready stays 0 for that channel, and pending clears.
  - A broadcast-hit channel completes that cycle and is not issued. If it was also the arbitration winner in the same cycle, the broadcast takes priority and the winner is suppressed.
  - Same channel returning and re-requesting in the same cycle: the new request is a candidate from the following cycle.
  - N_CHANNELS=1: the pointer is constant 0. Behaviour otherwise identical.
  - rst_n asserted mid-flight: the pipeline is flushed, in-flight data is discarded, and no ch_ready follows reset release.

Decomposition:
- Shared package (memory pkg):
  - typedef for the pipeline entry {valid, addr, mask}.
  - function clog2-based pointer width.
  - constant for the default latency.
- One natural sub-module: rr_arbiter, parametrised N. It takes a request vector and pointer and returns a one-hot grant and the next pointer. Verified standalone.

Test Plan:
- Single request: ch0 addr 0x010, memory returns 0xDEADBEEF, latency 1 -> mem_valid at cycle 0, ch_ready=0001 at cycle 2, ch_data=0xDEADBEEF, broadcast_addr=0x010.
- Round robin: all 4 channels request distinct addresses 0x1..0x4 continuously -> issue order ch0,ch1,ch2,ch3,ch0…, one mem_valid per cycle, each ch_ready exactly 2 cycles after its issue.
- Coalescing: ch1 and ch3 both request 0x055 in the same cycle -> single mem_valid, ch_ready=1010 together.
- Broadcast hit: ch2 requests 0x020 and is issued; ch0 requests 0x020 one cycle later -> no second mem access, ch_ready=0101 in the same cycle.
- Abandon: ch1 drops ch_valid while pending -> no ch_ready[1], broadcast_valid=1, and ch1's next request on a new address is issued normally.
- Reset mid-flight: assert rst_n=0 one cycle after issue with MEMORY_LATENCY=3 -> all outputs 0, no ch_ready after release, RR pointer restarts at ch0.
